card_eraser: RTL and testbench

CARD_ERASER -- requirements
Module: card_eraser

---
 rtl/card_pkg.sv | 34 +++
 rtl/card_eraser_if.sv | 19 +
 rtl/card_loc_decode.sv | 43 ++++
 rtl/card_eraser.sv | 164 ++++++++++++++++
 tb/tb_card_eraser.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// ---------------------------------------------------------------------------
// card_pkg -- shared constants for the card eraser.
//   Grid geometry : GRID_X0/GRID_Y0 (pixel origin of card 1), GRID_PITCH
//                   (distance between card origins), CARD_SIZE (edge length
//                   of the square erased per card).
//   FSM encoding  : ST_IDLE, ST_SLOT, ST_ERASE, ST_DONE.
//   slot_code()   : picks the 4-bit card code of one of the three slots.
// ---------------------------------------------------------------------------
package card_pkg;

    localparam int unsigned GRID_X0    = 50;
    localparam int unsigned GRID_Y0    = 30;
    localparam int unsigned GRID_PITCH = 20;
    localparam int unsigned CARD_SIZE  = 16;

    // Pixel counter value of the final pixel of a card.
    localparam logic [7:0] CNT_LAST  = 8'(CARD_SIZE * CARD_SIZE - 1);
    localparam logic [1:0] LAST_SLOT = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLOT  = 2'd1;
    localparam logic [1:0] ST_ERASE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [3:0] slot_code(input logic [11:0] loc,
                                             input logic [1:0]  slot);
        case (slot)
            2'd0:    return loc[3:0];
            2'd1:    return loc[7:4];
            default: return loc[11:8];
        endcase
    endfunction

endpackage

// File: rtl/card_eraser_if.sv
// ---------------------------------------------------------------------------
// card_eraser_if -- pixel write bus towards the VGA adapter.
//   x      : pixel column (8 bits)
//   y      : pixel row    (7 bits)
//   colour : pixel colour (3 bits)
//   plot   : write enable
//   master : pixel source (the eraser); slave : pixel sink (VGA adapter).
// ---------------------------------------------------------------------------
interface card_eraser_if;

    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);

endinterface

// File: rtl/card_loc_decode.sv
// ---------------------------------------------------------------------------
// card_loc_decode -- maps a card code to the top-left pixel of its card.
//   code   : card code, 1..9 valid, laid out row-major on a 3x3 grid
//   base_x : pixel column of the card's top-left corner
//   base_y : pixel row of the card's top-left corner
//   valid  : code is in 1..9 (base_x/base_y are don't-care otherwise)
// Purely combinational.
// ---------------------------------------------------------------------------
module card_loc_decode
    import card_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] base_x,
    output logic [6:0] base_y,
    output logic       valid
);

    logic [1:0] col;
    logic [1:0] row;

    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        col   = 2'd0;
        row   = 2'd0;
        valid = 1'b1;
        case (code)
            4'd1: begin col = 2'd0; row = 2'd0; end
            4'd2: begin col = 2'd1; row = 2'd0; end
            4'd3: begin col = 2'd2; row = 2'd0; end
            4'd4: begin col = 2'd0; row = 2'd1; end
            4'd5: begin col = 2'd1; row = 2'd1; end
            4'd6: begin col = 2'd2; row = 2'd1; end
            4'd7: begin col = 2'd0; row = 2'd2; end
            4'd8: begin col = 2'd1; row = 2'd2; end
            4'd9: begin col = 2'd2; row = 2'd2; end
            default: valid = 1'b0;
        endcase
        base_x = 8'(GRID_X0 + GRID_PITCH * 32'(col));
        base_y = 7'(GRID_Y0 + GRID_PITCH * 32'(row));
    end

endmodule

// File: rtl/card_eraser.sv
// ---------------------------------------------------------------------------
// card_eraser -- erases up to three cards from the screen per request.
//   clk          : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   start        : one-cycle request, honoured only while idle
//   locations    : three card codes, slot0=[3:0], slot1=[7:4], slot2=[11:8]
//   new_game     : clears cleared_mask, honoured only while idle
//   vga          : pixel bus (x, y, colour, plot), all registered
//   busy         : high while a request is in progress
//   done         : one-cycle pulse closing a request
//   cleared_mask : bit k-1 set once card k has been erased
//   all_cleared  : every card erased
// For each slot holding a valid code the 16x16 card area is overwritten
// row-major with colour 0, one pixel per cycle; invalid codes are skipped.
// ---------------------------------------------------------------------------
module card_eraser
    import card_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [11:0]   locations,
    input  logic          new_game,
    card_eraser_if.master vga,
    output logic          busy,
    output logic          done,
    output logic [8:0]    cleared_mask,
    output logic          all_cleared
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  slot_q,  slot_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [11:0] loc_q,   loc_d;
    logic [7:0]  x_q,     x_d;
    logic [6:0]  y_q,     y_d;
    logic        plot_q,  plot_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [8:0]  mask_q,  mask_d;

    logic [3:0] code;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic       code_valid;

    // The decoder follows the slot being worked on, so the base stays
    // stable for the whole ERASE phase of that slot.
    assign code = slot_code(loc_q, slot_q);

    card_loc_decode u_decode (
        .code   (code),
        .base_x (base_x),
        .base_y (base_y),
        .valid  (code_valid)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        loc_d   = loc_q;
        x_d     = x_q;
        y_d     = y_q;
        plot_d  = 1'b0;
        done_d  = 1'b0;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: begin
                if (new_game) begin
                    mask_d = '0;
                end
                if (start) begin
                    loc_d   = locations;
                    slot_d  = 2'd0;
                    state_d = ST_SLOT;
                end
            end

            ST_SLOT: begin
                if (code_valid) begin
                    // Outputs are registered, so the first pixel is set up
                    // here to appear together with plot in the first ERASE
                    // cycle.
                    cnt_d   = 8'd0;
                    plot_d  = 1'b1;
                    x_d     = base_x;
                    y_d     = base_y;
                    state_d = ST_ERASE;
                end else if (slot_q == LAST_SLOT) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    slot_d  = slot_q + 2'd1;
                end
            end

            ST_ERASE: begin
                if (cnt_q == CNT_LAST) begin
                    mask_d[code - 4'd1] = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                        state_d = ST_SLOT;
                    end
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    plot_d = 1'b1;
                    x_d    = base_x + {4'b0000, cnt_d[3:0]};
                    y_d    = base_y + {3'b000, cnt_d[7:4]};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: all state, including the latched locations, is reset so an
        // aborted request leaves nothing behind that could leak into the next.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= 2'd0;
            cnt_q   <= 8'd0;
            loc_q   <= 12'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            loc_q   <= loc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
        end
    end

    assign vga.x        = x_q;
    assign vga.y        = y_q;
    assign vga.colour   = 3'b000;
    assign vga.plot     = plot_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cleared_mask = mask_q;
    assign all_cleared  = &mask_q;

endmodule

// File: tb/tb_card_eraser.sv
// ---------------------------------------------------------------------------
// tb_card_eraser -- self-checking bench for card_eraser.
// A reference model turns each request into a per-cycle list of expected
// outputs using the grid arithmetic directly (col=(code-1)%3,
// row=(code-1)/3, 16x16 row-major sweep). Inputs change on the falling
// edge; outputs are sampled on the falling edge before new inputs are set.
// ---------------------------------------------------------------------------
module tb_card_eraser;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] locations;
    logic        new_game;
    logic        busy;
    logic        done;
    logic [8:0]  cleared_mask;
    logic        all_cleared;

    card_eraser_if vga_bus ();

    card_eraser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .locations    (locations),
        .new_game     (new_game),
        .vga          (vga_bus),
        .busy         (busy),
        .done         (done),
        .cleared_mask (cleared_mask),
        .all_cleared  (all_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       plot;
        int         x;
        int         y;
        logic       done;
        logic       busy;
        logic [8:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] model_mask;
    int         n_cmp;
    int         n_fail;

    task automatic check(input string tag, input int cyc,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d required %0d", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs for cycles 1..N after a start pulse in cycle 0.
    task automatic build_model(input logic [11:0] loc);
        logic [8:0] m;
        logic [11:0] l;
        exp_t e;
        m = model_mask;
        l = loc;
        exp_q.delete();
        for (int s = 0; s < 3; s++) begin
            int code;
            code = int'(l[4*s +: 4]);
            e = '{plot: 1'b0, x: 0, y: 0, done: 1'b0, busy: 1'b1, mask: m};
            exp_q.push_back(e);
            if (code >= 1 && code <= 9) begin
                int bx;
                int by;
                bx = 50 + 20 * ((code - 1) % 3);
                by = 30 + 20 * ((code - 1) / 3);
                for (int p = 0; p < 256; p++) begin
                    e = '{plot: 1'b1, x: bx + p % 16, y: by + p / 16,
                          done: 1'b0, busy: 1'b1, mask: m};
                    exp_q.push_back(e);
                end
                m[code - 1] = 1'b1;
            end
        end
        e = '{plot: 1'b0, x: 0, y: 0, done: 1'b1, busy: 1'b1, mask: m};
        exp_q.push_back(e);
        e = '{plot: 1'b0, x: 0, y: 0, done: 1'b0, busy: 1'b0, mask: m};
        exp_q.push_back(e);
    endtask

    // One request. restart_at/ng_at/abort_at are cycle numbers (<=0: unused)
    // at which start, new_game or reset_n=0 are applied during the request.
    task automatic run_request(input logic [11:0] loc, input int restart_at,
                               input logic [11:0] restart_loc, input int ng_at,
                               input int abort_at);
        int last;
        int plots_seen;
        int plots_exp;
        build_model(loc);
        last = (abort_at > 0) ? abort_at + 20 : exp_q.size();
        plots_seen = 0;
        plots_exp  = 0;
        foreach (exp_q[i]) if (exp_q[i].plot) plots_exp++;

        @(negedge clk);
        start     = 1'b1;
        locations = loc;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            if (vga_bus.plot === 1'b1) plots_seen++;
            if (abort_at > 0 && cyc > abort_at) begin
                check("abort_plot", cyc, 32'(vga_bus.plot), 32'd0);
                check("abort_done", cyc, 32'(done), 32'd0);
                check("abort_busy", cyc, 32'(busy), 32'd0);
                check("abort_mask", cyc, 32'(cleared_mask), 32'd0);
                check("abort_x", cyc, 32'(vga_bus.x), 32'd0);
                check("abort_y", cyc, 32'(vga_bus.y), 32'd0);
            end else begin
                exp_t e;
                e = exp_q[cyc - 1];
                check("plot", cyc, 32'(vga_bus.plot), 32'(e.plot));
                check("done", cyc, 32'(done), 32'(e.done));
                check("busy", cyc, 32'(busy), 32'(e.busy));
                check("mask", cyc, 32'(cleared_mask), 32'(e.mask));
                check("all_cleared", cyc, 32'(all_cleared), 32'(&e.mask));
                if (e.plot) begin
                    check("x", cyc, 32'(vga_bus.x), 32'(e.x));
                    check("y", cyc, 32'(vga_bus.y), 32'(e.y));
                    check("colour", cyc, 32'(vga_bus.colour), 32'd0);
                end
            end
            start    = (cyc == restart_at);
            new_game = (cyc == ng_at);
            reset_n  = !(cyc == abort_at);
            if (cyc == restart_at) locations = restart_loc;
        end
        start    = 1'b0;
        new_game = 1'b0;
        reset_n  = 1'b1;
        if (abort_at > 0) begin
            model_mask = 9'd0;
        end else begin
            check("plot_count", 0, 32'(plots_seen), 32'(plots_exp));
            model_mask = exp_q[exp_q.size() - 1].mask;
        end
    endtask

    task automatic idle_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_mask = 9'd0;
        check("new_game_mask", 0, 32'(cleared_mask), 32'd0);
        check("new_game_busy", 0, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        model_mask = 9'd0;
        reset_n    = 1'b0;
        start      = 1'b0;
        new_game   = 1'b0;
        locations  = 12'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_plot", 0, 32'(vga_bus.plot), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_done", 0, 32'(done), 32'd0);
        check("rst_mask", 0, 32'(cleared_mask), 32'd0);
        check("rst_x", 0, 32'(vga_bus.x), 32'd0);
        check("rst_y", 0, 32'(vga_bus.y), 32'd0);
        check("rst_colour", 0, 32'(vga_bus.colour), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 0, 32'(busy), 32'd0);

        // Cards 1, 5, 9: corner pixels (50,30) and (105,85), done at 772.
        run_request(12'h951, 0, 12'h000, 0, 0);
        check("mask_951", 0, 32'(cleared_mask), 32'(9'b100010001));

        // All slots invalid: nothing drawn, mask unchanged.
        run_request(12'h0F0, 0, 12'h000, 0, 0);
        check("mask_0F0", 0, 32'(cleared_mask), 32'(9'b100010001));

        // start and new_game while busy are ignored.
        run_request(12'h236, 100, 12'h777, 150, 0);

        // Reset in the middle of the second card.
        run_request(12'h951, 0, 12'h000, 0, 300);

        // Erase the whole board, then start a new game.
        idle_new_game();
        run_request(12'h321, 0, 12'h000, 0, 0);
        run_request(12'h654, 0, 12'h000, 0, 0);
        run_request(12'h987, 0, 12'h000, 0, 0);
        check("all_cleared", 0, 32'(all_cleared), 32'd1);
        idle_new_game();
        check("all_cleared_off", 0, 32'(all_cleared), 32'd0);

        // Random requests, including invalid codes and duplicates.
        for (int r = 0; r < 4; r++) begin
            logic [11:0] loc;
            loc = 12'($urandom);
            run_request(loc, int'($urandom_range(2, 400)), 12'($urandom),
                        int'($urandom_range(2, 400)), 0);
            if ($urandom_range(0, 1) == 1) idle_new_game();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
